fwd_hazard_unit: RTL

- Parametrised forwarding and hazard controller for the pipelined CPU; replaces the per-stage combinational forwarding compares.
- Tracks in-flight register writers in a shadow scoreboard that advances with the pipeline.
- Resolves source operands in ID and registers a per-source forward select for use in EX.
- Generates load-use stalls, taken-branch flushes and memory-wait freezes, and counts stall cycles.

---
 rtl/hazard_pkg.sv | 36 +++
 rtl/fwd_match.sv | 51 +++++
 rtl/fwd_hazard_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the forwarding/hazard controller.
// Scoreboard slots carry a fixed-width rd field; instances use the low REG_ADDR_W bits.
package hazard_pkg;

  localparam int FWD_SEL_RF     = 0;
  localparam int REG_ADDR_W_MAX = 8;

  // Ceiling log2, used to size the forward select.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  typedef struct packed {
    logic                      vld;
    logic                      is_load;
    logic [REG_ADDR_W_MAX-1:0] rd;
  } sb_slot_t;

  // Control priority, highest first: freeze > flush > load-use stall > run.
  typedef enum logic [1:0] {
    PRI_FREEZE   = 2'd0,
    PRI_FLUSH    = 2'd1,
    PRI_LOAD_USE = 2'd2,
    PRI_RUN      = 2'd3
  } hz_pri_e;

endpackage

// File: rtl/fwd_match.sv
// Youngest-match priority encoder for one source operand against the scoreboard.
// Returns the forward distance (0 = register file) and whether that producer is a too-young load.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int ZERO_REG   = 1,
  parameter int SEL_W      = 2
) (
  input  logic                    cand_en,
  input  logic [REG_ADDR_W-1:0]   src,
  input  sb_slot_t [FWD_STAGES-1:0] slots,
  output logic [SEL_W-1:0]        sel,
  output logic                    load_use
);

  logic                  cand_s;
  logic [FWD_STAGES-1:0] hit_s;
  logic [SEL_W-1:0]      sel_s;
  logic                  lu_s;

  // Per-slot hit vector for a live, non-hardwired source.
  always_comb begin
    cand_s = cand_en & ~((ZERO_REG != 0) && (src == '0));
    hit_s  = '0;
    for (int j = 0; j < FWD_STAGES; j++) begin
      hit_s[j] = cand_s & slots[j].vld & (slots[j].rd[REG_ADDR_W-1:0] == src);
    end
  end

  // Scan oldest to youngest so the nearest producer overrides.
  always_comb begin
    sel_s = SEL_W'(FWD_SEL_RF);
    lu_s  = 1'b0;
    for (int j = FWD_STAGES - 1; j >= 0; j--) begin
      if (hit_s[j]) begin
        sel_s = SEL_W'(j + 1);
        lu_s  = slots[j].is_load && ((j + 1) <= LOAD_LAT);
      end else begin
        sel_s = sel_s;
        lu_s  = lu_s;
      end
    end
  end

  assign sel      = sel_s;
  assign load_use = lu_s;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard controller: shadow scoreboard of in-flight writers, registered
// per-source forward selects for EX, stall/flush/freeze control and a load-use stall counter.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = clog2(FWD_STAGES + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_vld,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_use,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_wr,
  input  logic                          id_is_load,
  input  logic                          ex_br_taken,
  input  logic                          mem_wait,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          pc_write,
  output logic                          if_id_write,
  output logic                          if_id_flush,
  output logic                          id_ex_bubble,
  output logic [CNT_W-1:0]              stall_cnt
);

  sb_slot_t [FWD_STAGES-1:0] slots_r;
  sb_slot_t                  entry_s;
  logic [NUM_SRC*SEL_W-1:0]  sel_s;
  logic [NUM_SRC-1:0]        lu_s;
  hz_pri_e                   pri_s;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_match
    fwd_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .FWD_STAGES (FWD_STAGES),
      .LOAD_LAT   (LOAD_LAT),
      .ZERO_REG   (ZERO_REG),
      .SEL_W      (SEL_W)
    ) u_match (
      .cand_en  (id_vld & id_src_use[k]),
      .src      (id_src[k*REG_ADDR_W +: REG_ADDR_W]),
      .slots    (slots_r),
      .sel      (sel_s[k*SEL_W +: SEL_W]),
      .load_use (lu_s[k])
    );
  end

  // Resolve which control action owns this cycle.
  always_comb begin
    if (mem_wait) begin
      pri_s = PRI_FREEZE;
    end else if (ex_br_taken) begin
      pri_s = PRI_FLUSH;
    end else if (|lu_s) begin
      pri_s = PRI_LOAD_USE;
    end else begin
      pri_s = PRI_RUN;
    end
  end

  // Pipeline control; reset holds the front end and keeps bubbling ID/EX.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b1;
    if (!rst_n) begin
      id_ex_bubble = 1'b1;
    end else begin
      case (pri_s)
        PRI_FREEZE: begin
          id_ex_bubble = 1'b0;
        end
        PRI_FLUSH: begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        PRI_LOAD_USE: begin
          id_ex_bubble = 1'b1;
        end
        PRI_RUN: begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          id_ex_bubble = 1'b0;
        end
        default: begin
          id_ex_bubble = 1'b1;
        end
      endcase
    end
  end

  // Scoreboard entry for the ID instruction; a bubble enters as an empty slot.
  always_comb begin
    entry_s                  = '0;
    entry_s.vld              = id_vld & id_wr & ~((ZERO_REG != 0) && (id_rd == '0)) & ~id_ex_bubble;
    entry_s.is_load          = id_is_load;
    entry_s.rd[REG_ADDR_W-1:0] = id_rd;
  end

  // Scoreboard advance, forward-select register and stall counter; all hold under mem_wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_r   <= '0;
      fwd_sel   <= '0;
      stall_cnt <= '0;
    end else if (pri_s != PRI_FREEZE) begin
      slots_r[0] <= entry_s;
      for (int j = 1; j < FWD_STAGES; j++) begin
        slots_r[j] <= slots_r[j-1];
      end
      fwd_sel <= id_ex_bubble ? '0 : sel_s;
      if ((pri_s == PRI_LOAD_USE) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
